rgb565_burst_writer: RTL

- Downstream consumer of the RGB565 pattern generator and the DVP capture path. Takes the 16-bit RGB565 pixel stream plus the end-of-frame flag.
- Buffers pixels in a small FIFO and issues fixed-length write bursts to the SDRAM controller, with incrementing word addresses.
- At end of frame it pads any partial burst and reports completion.

---
 rtl/rgb565_burst_writer_pkg.sv | 12 +
 rtl/rgb565_burst_writer_if.sv | 28 ++
 rtl/rgb565_burst_writer_pixel_sync_fifo.sv | 65 ++++++
 rtl/rgb565_burst_writer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rgb565_burst_writer_pkg.sv
// Shared types and constants for the RGB565 burst writer.
package rgb565_writer_pkg;
    localparam int RGB565_W = 16;
    localparam logic [RGB565_W-1:0] PAD_PIXEL = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } writer_state_t;
endpackage

// File: rtl/rgb565_burst_writer_if.sv
// SDRAM write-burst bus between the writer (master) and the SDRAM controller (slave).
interface rgb565_burst_writer_if #(
    parameter int ADDR_W = 24
);
    import rgb565_writer_pkg::*;

    logic                wr_req;
    logic [ADDR_W-1:0]   wr_addr;
    logic                wr_ack;
    logic                wr_data_pull;
    logic [RGB565_W-1:0] wr_data;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack,
        input  wr_data_pull
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack,
        output wr_data_pull
    );
endinterface

// File: rtl/rgb565_burst_writer_pixel_sync_fifo.sv
// First-word-fall-through pixel FIFO with synchronous clear; DEPTH must be a power of two.
module pixel_sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/rgb565_burst_writer.sv
// Buffers an RGB565 pixel stream and writes it to SDRAM as fixed-length padded bursts.
// Optional pixel_count output enabled by defining RGB565_BURST_WRITER_PIXCNT_EN.
module rgb565_burst_writer
    import rgb565_writer_pkg::*;
#(
    parameter int                BURST_LEN  = 4,
    parameter int                FIFO_DEPTH = 16,
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] FRAME_BASE = '0
) (
    input  logic                  writer_clk,
    input  logic                  writer_reset,
    input  logic                  frame_start,
    input  logic [RGB565_W-1:0]   pixel_in,
    input  logic                  pixel_valid,
    input  logic                  frame_end,
    rgb565_burst_writer_if.master wr_bus,
`ifdef RGB565_BURST_WRITER_PIXCNT_EN
    output logic [23:0]           pixel_count,
`endif
    output logic                  frame_written,
    output logic                  fifo_overflow
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    writer_state_t       state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                pad_q, pad_d;
    logic                fe_l_q, fe_l_d;
    logic                ovf_q, ovf_d;

    logic                fifo_push, fifo_pop;
    logic [RGB565_W-1:0] fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full, fifo_empty;
    logic                arm;

    pixel_sync_fifo #(
        .WIDTH (RGB565_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (writer_clk),
        .srst  (writer_reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pixel_in),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // frame_start only re-arms when nothing of the previous frame is still in flight.
    assign arm       = frame_start && ((state_q == DONE) || (state_q == IDLE && fifo_empty));
    assign fifo_push = (state_q != DONE) && pixel_valid && !fifo_full;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        pad_d    = pad_q;
        fe_l_d   = fe_l_q | frame_end;
        ovf_d    = ovf_q | ((state_q != DONE) && pixel_valid && fifo_full);
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    addr_d = FRAME_BASE;
                    fe_l_d = 1'b0;
                    ovf_d  = 1'b0;
                end else if (fifo_count >= CNT_W'(BURST_LEN)) begin
                    state_d = REQ;
                end else if (fe_l_q && !fifo_empty) begin
                    state_d = REQ;
                    pad_d   = 1'b1;
                end else if (fe_l_q) begin
                    state_d = DONE;
                end
            end
            REQ: begin
                if (wr_bus.wr_ack) begin
                    state_d = BURST;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (wr_bus.wr_data_pull) begin
                    fifo_pop = !fifo_empty;
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        addr_d  = addr_q + ADDR_W'(BURST_LEN);
                        pad_d   = 1'b0;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (arm) begin
                    state_d = IDLE;
                    addr_d  = FRAME_BASE;
                    fe_l_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge writer_clk) begin
        if (writer_reset) begin
            state_q <= IDLE;
            addr_q  <= FRAME_BASE;
            beat_q  <= '0;
            pad_q   <= 1'b0;
            fe_l_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            pad_q   <= pad_d;
            fe_l_q  <= fe_l_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_bus.wr_req  = (state_q == REQ);
    assign wr_bus.wr_addr = addr_q;
    assign wr_bus.wr_data = fifo_empty ? PAD_PIXEL : fifo_head;
    assign frame_written  = (state_q == DONE);
    assign fifo_overflow  = ovf_q;

`ifdef RGB565_BURST_WRITER_PIXCNT_EN
    logic [23:0] pixcnt_q, pixcnt_d;

    always_comb begin
        pixcnt_d = pixcnt_q;
        if (arm) begin
            pixcnt_d = fifo_push ? 24'd1 : 24'd0;
        end else if (fifo_push && (pixcnt_q != '1)) begin
            pixcnt_d = pixcnt_q + 24'd1;
        end
    end

    always_ff @(posedge writer_clk) begin
        if (writer_reset) begin
            pixcnt_q <= '0;
        end else begin
            pixcnt_q <= pixcnt_d;
        end
    end

    assign pixel_count = pixcnt_q;
`endif
endmodule
